// File: rtl/weight_pkg.sv
// rtl/weight_pkg.sv - shared state type, default width and mask helpers for weight_enum8
package weight_pkg;

    localparam int N_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Smallest word of weight k: k ones packed at the bottom.
    function automatic logic [15:0] low_ones(input int k);
        return 16'((17'd1 << k) - 17'd1);
    endfunction

    // Largest word of weight k in an n-bit field: k ones packed at the top.
    function automatic logic [15:0] last_mask(input int n, input int k);
        return low_ones(k) << (n - k);
    endfunction

endpackage

// File: rtl/next_comb.sv
// rtl/next_comb.sv - Gosper step: next larger word with the same popcount
module next_comb #(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    output logic [N-1:0] nx
);

    localparam int TW = $clog2(N + 1);

    logic [N:0]    xe;
    logic [N:0]    c;
    logic [N:0]    r;
    logic [TW-1:0] tz;
    logic [TW:0]   shamt;

    // The carry-out bit of r only matters on the final word, which is never stepped.
    always_comb begin
        xe = {1'b0, x};
        c  = xe & (~xe + {{N{1'b0}}, 1'b1});
        r  = xe + c;
        tz = TW'(N);
        for (int i = N - 1; i >= 0; i--) begin
            if (x[i]) begin
                tz = TW'(i);
            end
        end
        shamt = {1'b0, tz} + (TW + 1)'(2);
        nx    = N'(r | ((r ^ xe) >> shamt));
    end

endmodule

// File: rtl/weight_enum8.sv
// rtl/weight_enum8.sv - streams every N-bit word of weight k in ascending order
module weight_enum8
    import weight_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int KW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] k,
    output logic          err,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  word,
    output logic          last,
    output logic [7:0]    index,
    output logic          done
);

    state_t        state_q, state_d;
    logic [N-1:0]  word_q, word_d;
    logic [KW-1:0] k_q, k_d;
    logic [7:0]    index_q, index_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    logic [N-1:0]  next_word;
    logic [N-1:0]  last_target;
    logic [N-1:0]  first_word;
    logic          last_word;
    logic          k_ok;

    next_comb #(
        .N(N)
    ) u_next (
        .x (word_q),
        .nx(next_word)
    );

    assign last_target = N'(last_mask(N, int'(k_q)));
    assign first_word  = N'(low_ones(int'(k)));
    assign last_word   = (word_q == last_target);
    assign k_ok        = (int'(k) <= N);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        k_d     = k_q;
        index_d = index_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_ok) begin
                        word_d  = first_word;
                        k_d     = k;
                        index_d = 8'd0;
                        state_d = EMIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                // start is deliberately not looked at here: a running stream cannot be retargeted.
                if (out_ready) begin
                    if (last_word) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        word_d  = next_word;
                        index_d = index_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            k_q     <= '0;
            index_q <= 8'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            k_q     <= k_d;
            index_q <= index_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign last      = out_valid & last_word;
    assign word      = word_q;
    assign index     = index_q;
    assign err       = err_q;
    assign done      = done_q;

endmodule
